four_one_demux_from_two_one_demux: RTL and testbench



---
 rtl/four_one_demux_pkg.sv | 9 +
 rtl/two_one_demux.sv | 15 +
 rtl/four_one_demux_from_two_one_demux.sv | 65 ++++++
 tb/tb_four_one_demux_from_two_one_demux.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/four_one_demux_pkg.sv
// Shared lane count, select width and select type for the 1-to-4 demux.
package four_one_demux_pkg;

    localparam int NUM_LANES = 4;
    localparam int SEL_W     = 2;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/two_one_demux.sv
// 1-to-2 demux cell: routes in to out0 (sel=0) or out1 (sel=1), other side zero.
// Latency: combinational. Backpressure: none.
module two_one_demux #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] in,
    input  logic             sel,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1
);

    assign out0 = sel ? '0 : in;
    assign out1 = sel ? in : '0;

endmodule

// File: rtl/four_one_demux_from_two_one_demux.sv
// Registered 1-to-4 demux from a tree of 1-to-2 cells; optional capture enable via FOUR_ONE_DEMUX_EN_PORT_EN.
// Latency: 1 clock from in/sel to out. Backpressure: none; en=0 (when present) holds out.
module four_one_demux_from_two_one_demux
    import four_one_demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef FOUR_ONE_DEMUX_EN_PORT_EN
    input  logic                       en,
`endif
    input  logic [WIDTH-1:0]           in,
    input  sel_t                       sel,
    output logic [NUM_LANES*WIDTH-1:0] out
);

    logic [WIDTH-1:0]           lower;
    logic [WIDTH-1:0]           upper;
    logic [WIDTH-1:0]           lane0;
    logic [WIDTH-1:0]           lane1;
    logic [WIDTH-1:0]           lane2;
    logic [WIDTH-1:0]           lane3;
    logic [NUM_LANES*WIDTH-1:0] nxt;
    logic                       capture;

    // sel[1] picks the lane pair, sel[0] picks the lane within the pair.
    two_one_demux #(.WIDTH(WIDTH)) u_stage1 (
        .in   (in),
        .sel  (sel[1]),
        .out0 (lower),
        .out1 (upper)
    );

    two_one_demux #(.WIDTH(WIDTH)) u_lower (
        .in   (lower),
        .sel  (sel[0]),
        .out0 (lane0),
        .out1 (lane1)
    );

    two_one_demux #(.WIDTH(WIDTH)) u_upper (
        .in   (upper),
        .sel  (sel[0]),
        .out0 (lane2),
        .out1 (lane3)
    );

    assign nxt = {lane3, lane2, lane1, lane0};

`ifdef FOUR_ONE_DEMUX_EN_PORT_EN
    assign capture = en;
`else
    assign capture = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
        end else if (capture) begin
            out <= nxt;
        end
    end

endmodule

// File: tb/tb_four_one_demux_from_two_one_demux.sv
// Bench for the registered 1-to-4 demux at WIDTH=1 and WIDTH=8: vector table, corner sequences, random vs model.
module tb_four_one_demux_from_two_one_demux;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  din;
    logic [1:0]  sel;
    logic [3:0]  out1;
    logic [31:0] out8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    four_one_demux_from_two_one_demux #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
`ifdef FOUR_ONE_DEMUX_EN_PORT_EN
        .en  (en),
`endif
        .in  (din[0]),
        .sel (sel),
        .out (out1)
    );

    four_one_demux_from_two_one_demux #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
`ifdef FOUR_ONE_DEMUX_EN_PORT_EN
        .en  (en),
`endif
        .in  (din),
        .sel (sel),
        .out (out8)
    );

    typedef struct {
        logic        rst;
        logic [7:0]  din;
        logic [1:0]  sel;
        logic [3:0]  exp1;
        logic [31:0] exp8;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step_and_check(input string name, input logic [3:0] e1, input logic [31:0] e8);
        @(posedge clk);
        #1;
        check({name, " w1"}, {28'b0, out1}, {28'b0, e1});
        check({name, " w8"}, out8, e8);
    endtask

    vec_t vecs[$];

    initial begin
        logic [3:0]  m1;
        logic [31:0] m8;

        rst = 1'b1; en = 1'b1; din = 8'h01; sel = 2'd2;

        // reset held two cycles, then release
        vecs.push_back('{1'b1, 8'h01, 2'd2, 4'b0000, 32'h0});
        vecs.push_back('{1'b1, 8'h01, 2'd2, 4'b0000, 32'h0});
        vecs.push_back('{1'b0, 8'h01, 2'd2, 4'b0100, 32'h0001_0000});
        // lane sweep
        vecs.push_back('{1'b0, 8'h01, 2'd0, 4'b0001, 32'h0000_0001});
        vecs.push_back('{1'b0, 8'h01, 2'd1, 4'b0010, 32'h0000_0100});
        vecs.push_back('{1'b0, 8'h01, 2'd2, 4'b0100, 32'h0001_0000});
        vecs.push_back('{1'b0, 8'h01, 2'd3, 4'b1000, 32'h0100_0000});
        // revisit pattern 0,2,2,0,1,3,1
        vecs.push_back('{1'b0, 8'h01, 2'd0, 4'b0001, 32'h0000_0001});
        vecs.push_back('{1'b0, 8'h01, 2'd2, 4'b0100, 32'h0001_0000});
        vecs.push_back('{1'b0, 8'h01, 2'd2, 4'b0100, 32'h0001_0000});
        vecs.push_back('{1'b0, 8'h01, 2'd0, 4'b0001, 32'h0000_0001});
        vecs.push_back('{1'b0, 8'h01, 2'd1, 4'b0010, 32'h0000_0100});
        vecs.push_back('{1'b0, 8'h01, 2'd3, 4'b1000, 32'h0100_0000});
        vecs.push_back('{1'b0, 8'h01, 2'd1, 4'b0010, 32'h0000_0100});
        // zero data
        vecs.push_back('{1'b0, 8'h00, 2'd0, 4'b0000, 32'h0});
        vecs.push_back('{1'b0, 8'h00, 2'd1, 4'b0000, 32'h0});
        vecs.push_back('{1'b0, 8'h00, 2'd2, 4'b0000, 32'h0});
        vecs.push_back('{1'b0, 8'h00, 2'd3, 4'b0000, 32'h0});
        // wide data, A5 has bit0 set so the narrow instance sees 1
        vecs.push_back('{1'b0, 8'hA5, 2'd3, 4'b1000, 32'hA500_0000});
        vecs.push_back('{1'b0, 8'hA5, 2'd0, 4'b0001, 32'h0000_00A5});
        // reset mid-stream discards the in-flight value
        vecs.push_back('{1'b0, 8'h3C, 2'd2, 4'b0000, 32'h003C_0000});
        vecs.push_back('{1'b1, 8'hFF, 2'd1, 4'b0000, 32'h0});
        vecs.push_back('{1'b0, 8'h81, 2'd1, 4'b0010, 32'h0000_8100});

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; din = vecs[i].din; sel = vecs[i].sel; en = 1'b1;
            step_and_check($sformatf("vec%0d", i), vecs[i].exp1, vecs[i].exp8);
        end

`ifdef FOUR_ONE_DEMUX_EN_PORT_EN
        rst = 1'b0; en = 1'b1; din = 8'h01; sel = 2'd1;
        step_and_check("en capture", 4'b0010, 32'h0000_0100);
        en = 1'b0; sel = 2'd3;
        step_and_check("en hold", 4'b0010, 32'h0000_0100);
        step_and_check("en hold2", 4'b0010, 32'h0000_0100);
        rst = 1'b1;
        step_and_check("rst over en", 4'b0000, 32'h0);
        rst = 1'b0;
        step_and_check("en hold zero", 4'b0000, 32'h0);
`endif

        // random traffic against an arithmetic model of the output register
        rst = 1'b1; en = 1'b1;
        @(posedge clk);
        #1;
        m1 = 4'b0; m8 = 32'b0;
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 19) == 0);
            din = 8'($urandom);
            sel = 2'($urandom);
`ifdef FOUR_ONE_DEMUX_EN_PORT_EN
            en  = ($urandom_range(0, 3) != 0);
`else
            en  = 1'b1;
`endif
            if (rst) begin
                m1 = 4'b0;
                m8 = 32'b0;
            end else if (en) begin
                m1 = {3'b0, din[0]} << sel;
                m8 = {24'b0, din} << (int'(sel) * 8);
            end
            step_and_check($sformatf("rand%0d", i), m1, m8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
